mem_arbiter: RTL and testbench

Single-port bus arbiter between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the 5-stage MIPS pipeline. It grants one multi-cycle bus transaction at a time, with fixed MEM-over-IF priority, and holds returned data until the owning stage advances. It raises `if_stall_request` / `mem_stall_request` toward the pipeline stall controller while a stage is waiting for its access.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arb_watchdog.sv | 38 +++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and constants for the IF/MEM bus arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_MEM = 2'd1,
    ARB_BUSY_IF  = 2'd2
  } arb_state_t;

  // Active level of the pipeline reset and stall-request lines.
  localparam logic RESET_ENABLE = 1'b1;
  localparam logic STALL_ENABLE = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Wide enough for the largest supported watchdog limit (1023).
  localparam int WDOG_CNT_W = 10;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - bus transaction watchdog counter with expiry pulse
module mem_arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic expire
);

  localparam logic [WDOG_CNT_W-1:0] LIMIT = WDOG_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_CNT_W-1:0] cnt_q;
  logic [WDOG_CNT_W-1:0] cnt_d;

  // Every grant starts from an idle cycle, so clearing while idle restarts the count per grant.
  always_comb begin
    cnt_d = '0;
    if (active) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th busy cycle without completion.
  assign expire = active && (cnt_q == LIMIT);

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset == RESET_ENABLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM single-port bus arbiter, MEM priority; watchdog under MEM_ARB_TIMEOUT_EN
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_hold,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_hold,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              if_stall_request,
  output logic              mem_stall_request,
  output logic              bus_error
);

  arb_state_t        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              done_if_q, done_if_d;
  logic              done_mem_q, done_mem_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              bus_error_q, bus_error_d;
  logic              timeout_expire;
  logic              complete;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .active (state_q != ARB_IDLE),
    .expire (timeout_expire)
  );
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout_expire = 1'b0;
`endif

  // A watchdog expiry finishes the access exactly like an ack, with zero data.
  assign complete = bus_ack | timeout_expire;

  // Grant, completion and done-flag bookkeeping.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    bus_error_d = bus_error_q;
    // A done flag survives only while its stage is stalled; completion below overrides.
    done_if_d   = if_hold & done_if_q;
    done_mem_d  = mem_hold & done_mem_q;

    case (state_q)
      ARB_IDLE: begin
        if (mem_req && !done_mem_q) begin
          state_d     = ARB_BUSY_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_sel_d   = mem_sel;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
        end else if (if_req && !done_if_q) begin
          state_d     = ARB_BUSY_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = 4'hF;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
        end
      end
      ARB_BUSY_MEM: begin
        if (complete) begin
          state_d     = ARB_IDLE;
          bus_req_d   = 1'b0;
          done_mem_d  = 1'b1;
          mem_rdata_d = (bus_ack && !bus_we_q) ? bus_rdata : '0;
        end
      end
      ARB_BUSY_IF: begin
        if (complete) begin
          state_d    = ARB_IDLE;
          bus_req_d  = 1'b0;
          done_if_d  = 1'b1;
          if_rdata_d = bus_ack ? bus_rdata : '0;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        bus_req_d = 1'b0;
      end
    endcase

    if (timeout_expire && !bus_ack) begin
      bus_error_d = 1'b1;
    end
  end

  // State, bus output and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset == RESET_ENABLE) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      done_if_q   <= 1'b0;
      done_mem_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      done_if_q   <= done_if_d;
      done_mem_q  <= done_mem_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_error = bus_error_q;
  assign if_ack    = done_if_q;
  assign mem_ack   = done_mem_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  assign if_stall_request  = STALL_ENABLE & if_req & ~done_if_q;
  assign mem_stall_request = STALL_ENABLE & mem_req & ~done_mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_hold, if_ack;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          mem_req, mem_we, mem_hold, mem_ack;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          bus_req, bus_we, bus_ack, bus_error;
  logic [3:0]    bus_sel;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          if_stall_request, mem_stall_request;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_hold(if_hold), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_hold(mem_hold), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .if_stall_request(if_stall_request), .mem_stall_request(mem_stall_request),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; if_hold = 0;
    mem_req = 0; mem_we = 0; mem_sel = '0; mem_addr = '0; mem_wdata = '0; mem_hold = 0;
    bus_ack = 0; bus_rdata = 32'hBAD0_0000;
  endtask

  // Transaction-level reference: who owns the bus, how long it has waited, and per-stage results.
  int            m_owner;  // 0 none, 1 MEM, 2 IF
  int            m_wait;
  logic          m_we, m_done_if, m_done_mem, m_err;
  logic [3:0]    m_sel;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_mem_rdata;

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_we = 0; m_sel = '0; m_addr = '0; m_wdata = '0;
    m_done_if = 0; m_done_mem = 0; m_err = 0; m_if_rdata = '0; m_mem_rdata = '0;
  endtask

  task automatic model_check();
    chk("rnd_bus_req", bus_req, m_owner != 0);
    if (m_owner != 0) begin
      chk("rnd_bus_addr", bus_addr, m_addr);
      chk("rnd_bus_we", bus_we, m_we);
    end
    if (m_owner == 1) begin
      chk("rnd_bus_sel", bus_sel, m_sel);
      chk("rnd_bus_wdata", bus_wdata, m_wdata);
    end
    chk("rnd_if_ack", if_ack, m_done_if);
    chk("rnd_mem_ack", mem_ack, m_done_mem);
    chk("rnd_if_rdata", if_rdata, m_if_rdata);
    chk("rnd_mem_rdata", mem_rdata, m_mem_rdata);
    chk("rnd_if_stall", if_stall_request, if_req & ~m_done_if);
    chk("rnd_mem_stall", mem_stall_request, mem_req & ~m_done_mem);
    chk("rnd_bus_error", bus_error, m_err);
  endtask

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_step();
    logic nd_if, nd_mem;
    logic [DW-1:0] val;
    nd_if  = if_hold ? m_done_if : 1'b0;
    nd_mem = mem_hold ? m_done_mem : 1'b0;
    if (m_owner != 0) begin
      if (bus_ack || (TO_ON && (m_wait + 1 >= TO))) begin
        val = (bus_ack && !m_we) ? bus_rdata : '0;
        if (m_owner == 1) begin m_mem_rdata = val; nd_mem = 1'b1; end
        else begin m_if_rdata = val; nd_if = 1'b1; end
        if (!bus_ack) m_err = 1'b1;
        m_owner = 0;
      end else begin
        m_wait++;
      end
    end else if (mem_req && !m_done_mem) begin
      m_owner = 1; m_wait = 0;
      m_addr = mem_addr; m_we = mem_we; m_sel = mem_sel; m_wdata = mem_wdata;
    end else if (if_req && !m_done_if) begin
      m_owner = 2; m_wait = 0;
      m_addr = if_addr; m_we = 1'b0;
    end
    m_done_if  = nd_if;
    m_done_mem = nd_mem;
  endtask

  initial begin
    int n_req;
    int n_stall;

    // ---- reset state ----
    reset = 1; idle_inputs();
    @(negedge clk); #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_mem_ack", mem_ack, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_error", bus_error, 0);
    @(negedge clk); reset = 0;

    // ---- IF read, ack on the third busy cycle ----
    @(negedge clk); if_req = 1; if_addr = 32'h40; if_hold = 1; #1;
    chk("t1_busreq_c0", bus_req, 0);
    n_req = 0; n_stall = if_stall_request;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); bus_ack = (i == 3); bus_rdata = (i == 3) ? 32'h2402_0005 : 32'hBAD0_0000 + i; #1;
      n_req += bus_req; n_stall += if_stall_request;
      chk("t1_bus_addr", bus_addr, 32'h40);
      chk("t1_bus_we", bus_we, 0);
    end
    @(negedge clk); bus_ack = 0; bus_rdata = 32'hBAD0_0000; if_hold = 0; #1;
    n_req += bus_req; n_stall += if_stall_request;
    chk("t1_if_ack", if_ack, 1);
    chk("t1_if_rdata", if_rdata, 32'h2402_0005);
    chk("t1_busreq_cycles", n_req, 3);
    chk("t1_stall_cycles", n_stall, 4);
    @(negedge clk); if_req = 0; #1;
    chk("t1_if_ack_clr", if_ack, 0);
    chk("t1_if_rdata_hold", if_rdata, 32'h2402_0005);

    // ---- simultaneous IF read and MEM write, 1-wait bus ----
    @(negedge clk);
    if_req = 1; if_addr = 32'h44; if_hold = 1;
    mem_req = 1; mem_we = 1; mem_addr = 32'h1000; mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF; mem_hold = 1;
    #1;
    chk("t2_c0_mem_stall", mem_stall_request, 1);
    chk("t2_c0_if_stall", if_stall_request, 1);
    @(negedge clk); #1;
    chk("t2_c1_bus_req", bus_req, 1);
    chk("t2_c1_bus_we", bus_we, 1);
    chk("t2_c1_bus_addr", bus_addr, 32'h1000);
    chk("t2_c1_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("t2_c1_bus_sel", bus_sel, 4'hF);
    @(negedge clk); bus_ack = 1; bus_rdata = 32'h5555_AAAA; #1;
    chk("t2_c2_bus_addr", bus_addr, 32'h1000);
    @(negedge clk); bus_ack = 0; mem_hold = 0; #1;
    chk("t2_c3_idle_gap", bus_req, 0);
    chk("t2_c3_mem_ack", mem_ack, 1);
    chk("t2_c3_mem_rdata", mem_rdata, 0);
    chk("t2_c3_mem_stall", mem_stall_request, 0);
    chk("t2_c3_if_stall", if_stall_request, 1);
    @(negedge clk); mem_req = 0; mem_we = 0; #1;
    chk("t2_c4_bus_req", bus_req, 1);
    chk("t2_c4_bus_we", bus_we, 0);
    chk("t2_c4_bus_addr", bus_addr, 32'h44);
    chk("t2_c4_mem_ack", mem_ack, 0);
    @(negedge clk);
    @(negedge clk); bus_ack = 1; bus_rdata = 32'h1234_5678;
    @(negedge clk); bus_ack = 0; if_hold = 0; #1;
    chk("t2_c7_if_ack", if_ack, 1);
    chk("t2_c7_if_rdata", if_rdata, 32'h1234_5678);
    chk("t2_c7_if_stall", if_stall_request, 0);
    @(negedge clk); if_req = 0;

    // ---- zero-wait MEM read completing while MEM stage holds for 3 cycles ----
    @(negedge clk); mem_req = 1; mem_addr = 32'h2000; mem_sel = 4'h3; mem_hold = 1; #1;
    chk("t3_c0_stall", mem_stall_request, 1);
    @(negedge clk); bus_ack = 1; bus_rdata = 32'hCAFE_F00D; #1;
    chk("t3_c1_stall", mem_stall_request, 1);
    chk("t3_c1_bus_sel", bus_sel, 4'h3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus_ack = 0; bus_rdata = $urandom; #1;
      chk("t3_hold_ack", mem_ack, 1);
      chk("t3_hold_rdata", mem_rdata, 32'hCAFE_F00D);
      chk("t3_hold_no_bus", bus_req, 0);
      chk("t3_hold_stall", mem_stall_request, 0);
    end
    @(negedge clk); mem_hold = 0; #1;
    chk("t3_release_ack", mem_ack, 1);
    @(negedge clk); mem_req = 0; #1;
    chk("t3_cleared_ack", mem_ack, 0);
    chk("t3_no_bus", bus_req, 0);

    // ---- reset in the middle of an IF transaction ----
    @(negedge clk); if_req = 1; if_addr = 32'h80; if_hold = 1;
    @(negedge clk); #1;
    chk("t4_busy", bus_req, 1);
    #2 reset = 1; #1;
    chk("t4_async_bus_req", bus_req, 0);
    chk("t4_async_bus_addr", bus_addr, 0);
    chk("t4_async_if_ack", if_ack, 0);
    chk("t4_async_mem_rdata", mem_rdata, 0);
    chk("t4_rst_stall", if_stall_request, 1);
    @(negedge clk); reset = 0; #1;
    chk("t4_release_bus_req", bus_req, 0);
    @(negedge clk); #1;
    chk("t4_regrant_from_idle", bus_req, 1);
    chk("t4_regrant_addr", bus_addr, 32'h80);
    @(negedge clk); bus_ack = 1; bus_rdata = 32'h0000_0077;
    @(negedge clk); bus_ack = 0; if_hold = 0; #1;
    chk("t4_if_ack", if_ack, 1);
    @(negedge clk); if_req = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    // ---- watchdog: bus never acks a MEM read ----
    @(negedge clk); mem_req = 1; mem_addr = 32'h3000; mem_hold = 1;
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (!bus_req) break;
      n_req++;
    end
    chk("t5_busreq_cycles", n_req, TO);
    chk("t5_mem_ack", mem_ack, 1);
    chk("t5_mem_rdata", mem_rdata, 0);
    chk("t5_bus_error", bus_error, 1);
    mem_hold = 0;
    @(negedge clk); mem_req = 0;
    @(negedge clk); if_req = 1; if_addr = 32'h90; if_hold = 1;
    @(negedge clk); bus_ack = 1; bus_rdata = 32'h0000_0011;
    @(negedge clk); bus_ack = 0; if_hold = 0; #1;
    chk("t5_later_if_ack", if_ack, 1);
    chk("t5_error_sticky", bus_error, 1);
    @(negedge clk); if_req = 0;
`endif

    // ---- randomized traffic against the reference model ----
    @(negedge clk); reset = 1; idle_inputs(); model_reset(); #1;
    model_check();
    @(negedge clk); reset = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if_req   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) if_addr = {$urandom} & 32'hFFFF_FFFC;
      if_hold  = $urandom_range(0, 1);
      mem_req  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        mem_we = $urandom_range(0, 1); mem_sel = 4'($urandom);
        mem_addr = $urandom; mem_wdata = $urandom;
      end
      mem_hold  = $urandom_range(0, 1);
      bus_ack   = (m_owner != 0) && ($urandom_range(0, 2) == 0);
      bus_rdata = $urandom;
      #1;
      model_check();
      model_step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
